seg_time_display: RTL
=====================

Name: seg_time_display

Overview:
- Consumer of the stopwatch count chain: takes the minutes and seconds values (each 0–59) and drives a 4-digit multiplexed 7-segment display in MM.SS form.
- Snapshots the inputs once per scan frame, converts each value to two BCD digits and time-multiplexes the four digits.
- Sits between the counter stages and the board display pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz → 1 kHz digit rate, 250 Hz frame); legal range ≥2.
- BLINK_DIV, 25000000, clk cycles per blink half-period (used only with the optional feature).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- minutes, input, 6, binary minutes value, 0–59.
- seconds, input, 6, binary seconds value, 0–59.
- blink, input, 1, blank request for the blink feature; ignored when the feature is compiled out.
- seg, output, 7, segment drive {g,f,e,d,c,b,a}, active low.
- dp, output, 1, decimal point, active low.
- an, output, 4, digit anodes, active low, one-hot or all-off.
- frame_start, output, 1, one-cycle pulse when the slot-0 snapshot is taken.

Behaviour:
- Reset (async, rst=1): seg=7'h7F, dp=1, an=4'hF, frame_start=0, divider=0, digit index=0, snapshots=0.
- Divider counts 0..REFRESH_DIV-1. On the terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
- Slot/digit mapping:
  - index 0: an[0], seconds ones.
  - index 1: an[1], seconds tens.
  - index 2: an[2], minutes ones; dp=0 (colon substitute).
  - index 3: an[3], minutes tens.
- dp=1 in every slot except index 2.
- Snapshot: on the cycle the index enters 0, minutes and seconds are registered into shadow regs and frame_start=1 for that cycle.
  - All four digits of a frame come from one snapshot; no tearing.
  - Latency from an input change to display is at most one frame plus one cycle.
  - The first frame after reset snapshots on the first cycle with rst=0 and index=0.
- Out-of-range value (>59) in a snapshot: both digits of that field show dash (seg=7'h3F, only g lit). The other field is unaffected.
- BCD conversion: tens = compare chain (≥50, ≥40, … ≥10); ones = value − 10·tens. Purely combinational on the shadow regs.
- Ghost suppression: an=4'hF for the first cycle of every slot (divider==0). The correct an and seg are driven from cycle 1 of the slot onward. seg is already valid on cycle 0.
- Outputs are registered and change only on clk edges, except under async reset.
- Reset asserted mid-frame: immediate return to reset values. The scan restarts at index 0 with a fresh snapshot.

Optional Feature:
- Macro: SEG_TIME_DISPLAY_BLINK_EN.
- Defined:
  - A blink counter toggles a phase bit every BLINK_DIV cycles.
  - While blink=1 and phase=1, an is forced to 4'hF; scanning and snapshots continue.
  - Phase resets to 0 on rst and whenever blink=0, so blanking starts BLINK_DIV cycles after blink rises.
- Undefined: blink is ignored, no blink counter is instantiated, and the display is never blanked beyond ghost suppression.

Decomposition:
- Package seg_time_pkg:
  - 7-bit active-low segment patterns for digits 0–9, dash and blank.
  - DIGITS=4.
  - 2-bit digit-index type.
- Sub-module bcd60_split (combinational): 6-bit in → tens[3:0], ones[3:0], invalid flag. Instantiated twice.
- Package decoder function maps BCD to segment pattern.

Test Plan:
- Reset check, REFRESH_DIV=4: assert rst mid-slot → seg=7'h7F, an=4'hF, dp=1 immediately (async). Release → frame_start pulses on the first clk edge.
- minutes=12, seconds=34, REFRESH_DIV=4: one frame shows an/seg pairs 1110/"4", 1101/"3", 1011/"2" with dp=0, 0111/"1". Each an is 4'hF on the slot's first cycle.
- Snapshot tearing: change seconds 34→35 during slot 1 → digits of the current frame still show 34; next frame shows 35, starting at frame_start.
- Boundaries: minutes=0, seconds=59 → "00.59". Then minutes=59, seconds=0 → "59.00". seconds=60 → seconds digits both 7'h3F, minutes digits normal.
- Wrap pass: drive the counter chain 59:59→00:00 → next frame shows "00.00" with no dash or partial frame.
- With SEG_TIME_DISPLAY_BLINK_EN, BLINK_DIV=8, blink=1:
  - an=4'hF for cycles 8–15, 24–31, … after blink rises.
  - frame_start pulses continue.
  - blink=0 → normal scan resumes on the next cycle.

Source files
------------

// File: rtl/seg_time_pkg.sv
// Shared types and segment patterns for the MM.SS display.
// Patterns are {g,f,e,d,c,b,a}, active low.
package seg_time_pkg;

    localparam int DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        case (d)
            4'd0: s = 7'h40;
            4'd1: s = 7'h79;
            4'd2: s = 7'h24;
            4'd3: s = 7'h30;
            4'd4: s = 7'h19;
            4'd5: s = 7'h12;
            4'd6: s = 7'h02;
            4'd7: s = 7'h78;
            4'd8: s = 7'h00;
            4'd9: s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_time_display_bcd60.sv
// Splits a 0-59 binary value into BCD tens/ones.
// Values above 59 raise invalid; digits are then don't-care.
module bcd60_split (
    input  logic [5:0] value,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       invalid
);

    logic [3:0] t10;

    // Compare chain for tens, subtract tens*10 (mod 16) for ones
    always_comb begin
        tens = 4'd0;
        if (value >= 6'd50)      tens = 4'd5;
        else if (value >= 6'd40) tens = 4'd4;
        else if (value >= 6'd30) tens = 4'd3;
        else if (value >= 6'd20) tens = 4'd2;
        else if (value >= 6'd10) tens = 4'd1;
        t10     = {tens[0], 3'b000} + {tens[2:0], 1'b0};
        ones    = value[3:0] - t10;
        invalid = (value > 6'd59);
    end

endmodule

// File: rtl/seg_time_display.sv
// Multiplexed 4-digit MM.SS driver with per-frame input snapshot.
// Optional blink blanking: define SEG_TIME_DISPLAY_BLINK_EN.
module seg_time_display
    import seg_time_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       blink,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int DW = $clog2(REFRESH_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

    logic [DW-1:0] div_q, div_n;
    digit_idx_t    idx_q, idx_n;
    logic          first_q;
    logic [5:0]    min_q, sec_q, min_n, sec_n;
    logic          take;
    logic [3:0]    m_t, m_o, s_t, s_o;
    logic          m_inv, s_inv;
    logic [3:0]    digit;
    logic          dig_inv;
    logic [6:0]    seg_n;
    logic [3:0]    an_n;
    logic          blank_n;

    // Next scan position and snapshot decision
    always_comb begin
        div_n = div_q + DW'(1);
        idx_n = idx_q;
        if (div_q == DIV_LAST) begin
            div_n = '0;
            idx_n = idx_q + 2'd1;
        end
        take  = first_q || ((div_q == DIV_LAST) && (idx_q == 2'd3));
        min_n = take ? minutes : min_q;
        sec_n = take ? seconds : sec_q;
    end

    bcd60_split u_min (
        .value   (min_n),
        .tens    (m_t),
        .ones    (m_o),
        .invalid (m_inv)
    );

    bcd60_split u_sec (
        .value   (sec_n),
        .tens    (s_t),
        .ones    (s_o),
        .invalid (s_inv)
    );

`ifdef SEG_TIME_DISPLAY_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] bcnt_q;
    logic          phase_q, phase_n;

    // Phase of the blink cycle as it will be after this edge
    always_comb begin
        phase_n = 1'b0;
        if (blink)
            phase_n = (bcnt_q == BLINK_LAST) ? ~phase_q : phase_q;
        blank_n = blink && phase_n;
    end

    // Blink counter, held cleared while blink is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else if (!blink) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= (bcnt_q == BLINK_LAST) ? '0 : bcnt_q + BW'(1);
            phase_q <= phase_n;
        end
    end
`else
    logic blink_unused;
    assign blink_unused = blink & (BLINK_DIV > 0);
    assign blank_n = 1'b0;
`endif

    // Digit select and anode pattern for the upcoming cycle
    always_comb begin
        digit   = 4'd0;
        dig_inv = 1'b0;
        unique case (idx_n)
            2'd0: begin digit = s_o; dig_inv = s_inv; end
            2'd1: begin digit = s_t; dig_inv = s_inv; end
            2'd2: begin digit = m_o; dig_inv = m_inv; end
            2'd3: begin digit = m_t; dig_inv = m_inv; end
        endcase
        seg_n = dig_inv ? SEG_DASH : bcd_to_seg(digit);
        an_n  = 4'hF;
        if ((div_n != '0) && !blank_n)
            an_n = ~(4'b0001 << idx_n);
    end

    // Scan state, snapshot and registered pin drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            idx_q       <= '0;
            first_q     <= 1'b1;
            min_q       <= '0;
            sec_q       <= '0;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            an          <= 4'hF;
            frame_start <= 1'b0;
        end else begin
            div_q       <= div_n;
            idx_q       <= idx_n;
            first_q     <= 1'b0;
            min_q       <= min_n;
            sec_q       <= sec_n;
            seg         <= seg_n;
            dp          <= (idx_n != 2'd2);
            an          <= an_n;
            frame_start <= take;
        end
    end

endmodule
